// File: rtl/auto_pkg.sv
// Shared constants and types for the automorphism ROM read sequencer.
package auto_pkg;

  localparam int DEF_DLEN = 32;
  localparam int DEF_HLEN = 7;

  localparam logic [1:0] LANE_EVEN_A = 2'd0;
  localparam logic [1:0] LANE_EVEN_B = 2'd1;
  localparam logic [1:0] LANE_ODD_A  = 2'd2;
  localparam logic [1:0] LANE_ODD_B  = 2'd3;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  typedef struct packed {
    logic [3:0][DEF_DLEN-1:0] data;
    logic [DEF_HLEN-2:0]      idx;
    logic                     last;
  } beat_t;

endpackage

// File: rtl/auto_skid_fifo.sv
// Two-entry FIFO that absorbs the ROM read latency; the head entry drives the output stream.
module auto_skid_fifo #(
  parameter type entry_t = auto_pkg::beat_t
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  entry_t     wdata,
  output entry_t     head,
  output logic       full,
  output logic       empty,
  output logic [1:0] count
);

  entry_t mem [2];
  logic   rd_ptr;
  logic   wr_ptr;
  logic   do_push;
  logic   do_pop;

  // A push into a full FIFO is only accepted when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/auto_rom_reader.sv
// Sweeps the even/odd automorphism ROM banks and streams 4-lane beats downstream,
// issuing reads only when the skid FIFO is guaranteed room for every read in flight.
module auto_rom_reader
  import auto_pkg::*;
#(
  parameter int DLEN = DEF_DLEN,
  parameter int HLEN = DEF_HLEN
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic [1:0][HLEN-1:0]      rom_addr_a,
  output logic [1:0][HLEN-1:0]      rom_addr_b,
  input  logic [1:0][DLEN-1:0]      rom_do_a,
  input  logic [1:0][DLEN-1:0]      rom_do_b,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [3:0][DLEN-1:0]      out_data,
  output logic [HLEN-2:0]           out_idx,
  output logic                      out_last
);

  localparam int IW = HLEN - 1;
  localparam int NBEATS = 2 ** IW;
  localparam logic [IW-1:0] LAST_IDX = IW'(NBEATS - 1);

  typedef struct packed {
    logic [3:0][DLEN-1:0] data;
    logic [IW-1:0]        idx;
    logic                 last;
  } sweep_beat_t;

  state_t      state;
  logic [IW-1:0] issue_idx;
  logic [IW-1:0] cur_idx;
  logic [IW-1:0] s1_idx;
  logic [IW-1:0] s2_idx;
  logic        s1_valid;
  logic        s2_valid;
  logic        issue_en;
  logic        issue_fire;
  logic        push;
  logic        pop;
  logic        fifo_full;
  logic        fifo_empty;
  logic [1:0]  fifo_count;
  sweep_beat_t push_beat;
  sweep_beat_t head;

  // Beat 0 is issued on the accepting edge, so IDLE always targets index 0.
  always_comb begin
    cur_idx    = (state == IDLE) ? '0 : issue_idx;
    issue_en   = ({1'b0, fifo_count} + {2'b00, s1_valid} + {2'b00, s2_valid})
                 < (3'd2 + {2'b00, pop});
    issue_fire = (state == IDLE) ? start : ((state == ISSUE) && issue_en);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      issue_idx  <= '0;
      rom_addr_a <= '0;
      rom_addr_b <= '0;
    end else begin
      done <= 1'b0;
      if (issue_fire) begin
        rom_addr_a <= {2{{1'b0, cur_idx}}};
        rom_addr_b <= {2{{1'b1, cur_idx}}};
      end
      unique case (state)
        IDLE: begin
          if (start) begin
            state     <= ISSUE;
            busy      <= 1'b1;
            issue_idx <= IW'(1);
          end
        end
        ISSUE: begin
          if (issue_en) begin
            if (issue_idx == LAST_IDX) state <= DRAIN;
            else                       issue_idx <= issue_idx + IW'(1);
          end
        end
        DRAIN: begin
          if (pop && head.last) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag pipeline shadowing the address register and the ROM output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_idx   <= '0;
      s2_idx   <= '0;
    end else begin
      s1_valid <= issue_fire;
      if (issue_fire) s1_idx <= cur_idx;
      s2_valid <= s1_valid;
      s2_idx   <= s1_idx;
    end
  end

  always_comb begin
    push_beat                   = '0;
    push_beat.data[LANE_EVEN_A] = rom_do_a[0];
    push_beat.data[LANE_EVEN_B] = rom_do_b[0];
    push_beat.data[LANE_ODD_A]  = rom_do_a[1];
    push_beat.data[LANE_ODD_B]  = rom_do_b[1];
    push_beat.idx               = s2_idx;
    push_beat.last              = (s2_idx == LAST_IDX);
  end

  assign push = s2_valid;
  assign pop  = out_valid && out_ready;

  auto_skid_fifo #(
    .entry_t (sweep_beat_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (push_beat),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = head.data;
  assign out_idx   = head.idx;
  assign out_last  = head.last;

  assert property (@(posedge clk) disable iff (rst) !(push && fifo_full && !pop));

endmodule

// File: tb/tb_auto_rom_reader.sv
// Scoreboard bench: a behavioural ROM feeds the reader, expected sweeps are queued at start and popped by a monitor.
module tb_auto_rom_reader;

  localparam int DLEN  = 32;
  localparam int HLEN  = 7;
  localparam int DEPTH = 2 ** HLEN;
  localparam int NB    = DEPTH / 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic out_ready = 1'b0;
  logic busy, done, out_valid, out_last;
  logic [1:0][HLEN-1:0] rom_addr_a, rom_addr_b;
  logic [1:0][DLEN-1:0] rom_do_a, rom_do_b;
  logic [3:0][DLEN-1:0] out_data;
  logic [HLEN-2:0]      out_idx;

  typedef struct {
    logic [4*DLEN-1:0] data;
    int                idx;
    bit                last;
  } exp_beat_t;

  exp_beat_t exp_q[$];

  int errors = 0;
  int checks = 0;
  int cycle_cnt = 0;
  int start_cycle = 0;
  int done_count = 0;
  int ready_mode = 0;
  int stall_left = 0;
  bit model_busy = 0;
  bit first_pending = 0;
  bit last_hs_prev = 0;
  bit prev_stall = 0;
  logic [4*DLEN-1:0] held_data;
  logic [HLEN-2:0]   held_idx;

  logic [DLEN-1:0] even_mem [DEPTH];
  logic [DLEN-1:0] odd_mem  [DEPTH];

  auto_rom_reader #(.DLEN(DLEN), .HLEN(HLEN)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .rom_addr_a (rom_addr_a),
    .rom_addr_b (rom_addr_b),
    .rom_do_a   (rom_do_a),
    .rom_do_b   (rom_do_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_idx    (out_idx),
    .out_last   (out_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle_cnt++;

  // Behavioural ROM: one registered read per port, even bank on index 0.
  always @(posedge clk) begin
    rom_do_a[0] <= even_mem[rom_addr_a[0]];
    rom_do_b[0] <= even_mem[rom_addr_b[0]];
    rom_do_a[1] <= odd_mem[rom_addr_a[1]];
    rom_do_b[1] <= odd_mem[rom_addr_b[1]];
  end

  task automatic checkOutput(input string name, input logic [4*DLEN-1:0] act,
                             input logic [4*DLEN-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Downstream ready pattern: 0 always ready, 1 random, 2 stall 20 cycles on beat 10.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'($urandom % 2);
      2: begin
        if (out_valid && out_idx == 10 && stall_left > 0) begin
          out_ready = 1'b0;
          stall_left--;
        end else begin
          out_ready = 1'b1;
        end
      end
      default: out_ready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    exp_beat_t e;
    int outst;
    if (rst) begin
      prev_stall   = 0;
      last_hs_prev = 0;
    end else begin
      if (done || last_hs_prev) checkOutput("done_timing", done, last_hs_prev);
      if (done) begin
        done_count++;
        checkOutput("busy_low_at_done", busy, 0);
      end
      checkOutput("busy", busy, model_busy);
      if (prev_stall) begin
        checkOutput("stall_valid", out_valid, 1);
        checkOutput("stall_data", out_data, held_data);
        checkOutput("stall_idx", out_idx, held_idx);
      end
      if (first_pending && out_valid) begin
        checkOutput("first_beat_latency", cycle_cnt - start_cycle + 1, 3);
        first_pending = 0;
      end
      if (out_valid && !out_ready) begin
        outst = int'(dut.fifo_count) + int'(dut.s1_valid) + int'(dut.s2_valid);
        checkOutput("outstanding_le_2", outst <= 2, 1);
      end
      last_hs_prev = 0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_beat: got idx %0d, required no beat", out_idx);
        end else begin
          e = exp_q.pop_front();
          checkOutput("beat_data", out_data, e.data);
          checkOutput("beat_idx", out_idx, e.idx);
          checkOutput("beat_last", out_last, e.last);
          if (e.last) begin
            last_hs_prev = 1;
            model_busy   = 0;
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      held_data  = out_data;
      held_idx   = out_idx;
    end
  end

  task automatic applyStimulus(input bit expect_accept);
    exp_beat_t e;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    if (expect_accept) begin
      for (int i = 0; i < NB; i++) begin
        e.data = {32'(32'h2000 + i + NB), 32'(32'h2000 + i),
                  32'(32'h1000 + i + NB), 32'(32'h1000 + i)};
        e.idx  = i;
        e.last = (i == NB - 1);
        exp_q.push_back(e);
      end
      start_cycle   = cycle_cnt;
      first_pending = 1;
      model_busy    = 1;
    end
  endtask

  task automatic waitDone(input string name);
    int n = 0;
    while (!done && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_timeout: got no done after %0d cycles, required done", name, n);
    end
    checkOutput({name, "_all_beats_delivered"}, exp_q.size(), 0);
  endtask

  task automatic waitIdx(input int idx);
    int n = 0;
    while (!(out_valid && out_idx == idx) && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!(out_valid && out_idx == idx)) begin
      checks++;
      errors++;
      $display("[TB] FAIL wait_idx_timeout: got idx %0d, required %0d", out_idx, idx);
    end
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got no finish, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int k = 0; k < DEPTH; k++) begin
      even_mem[k] = 32'(32'h1000 + k);
      odd_mem[k]  = 32'(32'h2000 + k);
    end
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_out_data", out_data, 0);
    checkOutput("reset_out_idx", out_idx, 0);
    checkOutput("reset_out_last", out_last, 0);
    checkOutput("reset_addr_a", rom_addr_a, 0);
    checkOutput("reset_addr_b", rom_addr_b, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    ready_mode = 0;
    applyStimulus(1);
    waitDone("free_run");

    ready_mode = 1;
    applyStimulus(1);
    waitDone("random_ready");

    stall_left = 20;
    ready_mode = 2;
    applyStimulus(1);
    waitDone("long_stall");
    checkOutput("stall_consumed", stall_left, 0);
    ready_mode = 0;

    applyStimulus(1);
    waitIdx(30);
    applyStimulus(0);
    waitDone("start_while_busy");
    repeat (10) @(posedge clk);
    #1;
    checkOutput("done_count_after_busy_start", done_count, 4);

    applyStimulus(1);
    waitIdx(20);
    rst           = 1'b1;
    model_busy    = 0;
    first_pending = 0;
    exp_q.delete();
    #1;
    checkOutput("midreset_out_valid", out_valid, 0);
    checkOutput("midreset_busy", busy, 0);
    checkOutput("midreset_done", done, 0);
    checkOutput("midreset_out_idx", out_idx, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("no_done_after_reset", done_count, 4);

    applyStimulus(1);
    waitDone("after_reset");
    applyStimulus(1);
    waitDone("back_to_back");
    repeat (5) @(posedge clk);
    #1;
    checkOutput("final_done_count", done_count, 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
